// File: rtl/space_pkg.sv
// rtl/space_pkg.sv - shared types, screen limits and priority encoder for the space game
package space_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    PENDING = 3'd2,
    COMMIT  = 3'd3,
    CLEARED = 3'd4
  } hit_state_t;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int MAX_ENEMIES = 8;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_set_idx(input logic [MAX_ENEMIES-1:0] vec);
    lowest_set_idx = 3'd0;
    for (int i = MAX_ENEMIES - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - two-flop synchroniser and rising-edge strobe for frame_clk
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the raw strobe through the synchroniser and keep one delayed copy for edge detect.
  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchroniser and edge-detect registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // One-cycle pulse on the synchronised rising edge.
  always_comb begin
    frame_tick = sync2_q & ~prev_q;
  end

endmodule

// File: rtl/enemy_hit_tracker.sv
// rtl/enemy_hit_tracker.sv - missile/enemy overlap detection, once-per-frame retire and scoring
module enemy_hit_tracker
  import space_pkg::*;
#(
  parameter int N_ENEMIES = 5,
  parameter int POINTS    = 10,
  parameter int SCORE_W   = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 Start,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [N_ENEMIES-1:0] enemy_on_vec,
  input  logic                 missile_on,
  output logic [N_ENEMIES-1:0] alive,
  output logic                 missile_hit,
  output logic [2:0]           hit_index,
  output logic [SCORE_W-1:0]   score,
  output logic                 wave_clear
);

  hit_state_t             state_q, state_d;
  logic [N_ENEMIES-1:0]   alive_q, alive_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [2:0]             pend_idx_q, pend_idx_d;
  logic [2:0]             hit_index_q, hit_index_d;

  logic                   frame_tick;
  logic                   on_screen;
  logic [N_ENEMIES-1:0]   hit_vec;
  logic                   hit_any;
  logic [N_ENEMIES-1:0]   kill_mask;
  logic [N_ENEMIES-1:0]   alive_after_kill;
  logic [SCORE_W:0]       score_sum;
  logic [SCORE_W-1:0]     score_sat;

  frame_tick_sync u_frame_tick_sync (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // Qualify overlap against the visible area and the live enemies; derive commit values.
  always_comb begin
    on_screen        = (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
    hit_vec          = enemy_on_vec & alive_q & {N_ENEMIES{missile_on & on_screen}};
    hit_any          = |hit_vec;
    kill_mask        = N_ENEMIES'(1) << pend_idx_q;
    alive_after_kill = alive_q & ~kill_mask;
    score_sum        = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
    score_sat        = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: at most one kill latched per frame, committed on the following tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start)      state_d = ARMED;
      ARMED:   if (hit_any)    state_d = PENDING;
      PENDING: if (frame_tick) state_d = COMMIT;
      COMMIT:  state_d = (alive_after_kill == '0) ? CLEARED : ARMED;
      CLEARED: if (Start)      state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates driven by the current state.
  always_comb begin
    alive_d     = alive_q;
    score_d     = score_q;
    pend_idx_d  = pend_idx_q;
    hit_index_d = hit_index_q;
    case (state_q)
      IDLE, CLEARED: if (Start) alive_d = '1;
      ARMED:   if (hit_any) pend_idx_d = lowest_set_idx(MAX_ENEMIES'(hit_vec));
      PENDING: if (frame_tick) hit_index_d = pend_idx_q;
      COMMIT: begin
        alive_d = alive_after_kill;
        score_d = score_sat;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears mask, score and any latched hit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      alive_q     <= '0;
      score_q     <= '0;
      pend_idx_q  <= 3'd0;
      hit_index_q <= 3'd0;
    end else begin
      alive_q     <= alive_d;
      score_q     <= score_d;
      pend_idx_q  <= pend_idx_d;
      hit_index_q <= hit_index_d;
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    alive       = alive_q;
    score       = score_q;
    hit_index   = hit_index_q;
    missile_hit = (state_q == COMMIT);
    wave_clear  = (state_q == CLEARED);
  end

endmodule

// File: tb/tb_enemy_hit_tracker.sv
// tb/tb_enemy_hit_tracker.sv - self-checking bench for enemy_hit_tracker
module tb_enemy_hit_tracker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       Start = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [4:0] enemy_on_vec = '0;
  logic       missile_on = 1'b0;

  logic [4:0]  alive, alive_s;
  logic        missile_hit, missile_hit_s;
  logic [2:0]  hit_index, hit_index_s;
  logic [15:0] score;
  logic [5:0]  score_s;
  logic        wave_clear, wave_clear_s;

  int n_checks = 0;
  int n_pass = 0;
  int pulse_cnt = 0;
  logic [2:0] last_idx = '0;

  enemy_hit_tracker #(.N_ENEMIES(5), .POINTS(10), .SCORE_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Start(Start),
    .DrawX(DrawX), .DrawY(DrawY), .enemy_on_vec(enemy_on_vec), .missile_on(missile_on),
    .alive(alive), .missile_hit(missile_hit), .hit_index(hit_index),
    .score(score), .wave_clear(wave_clear)
  );

  enemy_hit_tracker #(.N_ENEMIES(5), .POINTS(10), .SCORE_W(6)) dut_small (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Start(Start),
    .DrawX(DrawX), .DrawY(DrawY), .enemy_on_vec(enemy_on_vec), .missile_on(missile_on),
    .alive(alive_s), .missile_hit(missile_hit_s), .hit_index(hit_index_s),
    .score(score_s), .wave_clear(wave_clear_s)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) begin
    if (missile_hit) begin
      pulse_cnt <= pulse_cnt + 1;
      last_idx  <= hit_index;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic restart();
    Reset = 1'b1; step(2);
    Reset = 1'b0; Start = 1'b1; step(1);
    Start = 1'b0; step(1);
  endtask

  task automatic drive_hit(input logic [4:0] vec, input int x, input int y);
    enemy_on_vec = vec; missile_on = 1'b1; DrawX = 10'(x); DrawY = 10'(y);
    step(1);
    enemy_on_vec = '0; missile_on = 1'b0; DrawX = '0; DrawY = '0;
  endtask

  task automatic frame_pulse(output int pulses);
    int c0;
    c0 = pulse_cnt;
    frame_clk = 1'b1; step(6);
    frame_clk = 1'b0; step(3);
    pulses = pulse_cnt - c0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; step(3);
    n_checks++; if (alive !== 5'b00000) $display("FAIL reset_alive got %b want 00000", alive); else n_pass++;
    n_checks++; if (score !== 16'd0) $display("FAIL reset_score got %0d want 0", score); else n_pass++;
    n_checks++; if (missile_hit !== 1'b0 || hit_index !== 3'd0) $display("FAIL reset_hit got %b/%0d want 0/0", missile_hit, hit_index); else n_pass++;
    n_checks++; if (wave_clear !== 1'b0) $display("FAIL reset_wave_clear got %b want 0", wave_clear); else n_pass++;
    Reset = 1'b0; step(2);
    n_checks++; if (alive !== 5'b00000) $display("FAIL idle_no_start_alive got %b want 00000", alive); else n_pass++;
    Start = 1'b1; step(1); Start = 1'b0; step(1);
    n_checks++; if (alive !== 5'b11111) $display("FAIL start_alive got %b want 11111", alive); else n_pass++;
    n_checks++; if (score !== 16'd0 || wave_clear !== 1'b0) $display("FAIL start_score_clear got %0d/%b want 0/0", score, wave_clear); else n_pass++;
  endtask

  task automatic test_single_hit();
    logic [5:0] mh;
    logic [2:0] idx_at_pulse;
    restart();
    drive_hit(5'b00100, 100, 50);
    step(2);
    n_checks++; if (alive !== 5'b11111 || missile_hit !== 1'b0) $display("FAIL pending_no_commit got %b/%b want 11111/0", alive, missile_hit); else n_pass++;
    idx_at_pulse = 3'd7;
    mh = '0;
    frame_clk = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      mh[k] = missile_hit;
      if (missile_hit) idx_at_pulse = hit_index;
    end
    frame_clk = 1'b0; step(3);
    n_checks++; if (mh[5:1] !== 5'b00100) $display("FAIL hit_latency got %b want 00100", mh[5:1]); else n_pass++;
    n_checks++; if (idx_at_pulse !== 3'd2) $display("FAIL hit_index got %0d want 2", idx_at_pulse); else n_pass++;
    n_checks++; if (alive !== 5'b11011) $display("FAIL single_alive got %b want 11011", alive); else n_pass++;
    n_checks++; if (score !== 16'd10) $display("FAIL single_score got %0d want 10", score); else n_pass++;
  endtask

  task automatic test_priority_and_bounds();
    int p;
    restart();
    drive_hit(5'b00001, 640, 10);
    drive_hit(5'b00001, 10, 480);
    frame_pulse(p);
    n_checks++; if (p !== 0 || alive !== 5'b11111) $display("FAIL offscreen got pulses %0d alive %b want 0 11111", p, alive); else n_pass++;
    drive_hit(5'b01010, 639, 479);
    frame_pulse(p);
    n_checks++; if (p !== 1 || last_idx !== 3'd1) $display("FAIL priority_pulse got %0d idx %0d want 1 idx 1", p, last_idx); else n_pass++;
    n_checks++; if (alive !== 5'b11101 || score !== 16'd10) $display("FAIL priority_alive got %b score %0d want 11101 10", alive, score); else n_pass++;
  endtask

  task automatic test_two_hits_one_frame();
    int p;
    restart();
    drive_hit(5'b00001, 20, 20);
    step(1);
    drive_hit(5'b01000, 30, 30);
    frame_pulse(p);
    n_checks++; if (p !== 1 || last_idx !== 3'd0 || alive !== 5'b11110) $display("FAIL two_hits_first got pulses %0d idx %0d alive %b want 1 0 11110", p, last_idx, alive); else n_pass++;
    frame_pulse(p);
    n_checks++; if (p !== 0 || alive !== 5'b11110) $display("FAIL idle_tick got pulses %0d alive %b want 0 11110", p, alive); else n_pass++;
    Start = 1'b1; step(3); Start = 1'b0; step(1);
    n_checks++; if (alive !== 5'b11110) $display("FAIL start_in_armed got %b want 11110", alive); else n_pass++;
    drive_hit(5'b01000, 30, 30);
    frame_pulse(p);
    n_checks++; if (p !== 1 || last_idx !== 3'd3 || alive !== 5'b10110 || score !== 16'd20) $display("FAIL two_hits_second got pulses %0d idx %0d alive %b score %0d want 1 3 10110 20", p, last_idx, alive, score); else n_pass++;
  endtask

  task automatic test_tick_same_cycle();
    int p, c0;
    restart();
    c0 = pulse_cnt;
    frame_clk = 1'b1; step(2);
    drive_hit(5'b10000, 300, 200);
    step(4);
    frame_clk = 1'b0; step(3);
    n_checks++; if (pulse_cnt - c0 !== 0 || alive !== 5'b11111) $display("FAIL tick_with_hit got pulses %0d alive %b want 0 11111", pulse_cnt - c0, alive); else n_pass++;
    frame_pulse(p);
    n_checks++; if (p !== 1 || last_idx !== 3'd4 || alive !== 5'b01111) $display("FAIL tick_with_hit_next got pulses %0d idx %0d alive %b want 1 4 01111", p, last_idx, alive); else n_pass++;
  endtask

  task automatic test_wave_clear_and_saturation();
    int p;
    restart();
    for (int i = 0; i < 5; i++) begin
      drive_hit(5'(1 << i), 200, 100);
      frame_pulse(p);
      n_checks++; if (p !== 1 || last_idx !== 3'(i)) $display("FAIL wave_kill%0d got pulses %0d idx %0d want 1 %0d", i, p, last_idx, i); else n_pass++;
    end
    n_checks++; if (alive !== 5'b00000 || wave_clear !== 1'b1) $display("FAIL wave_clear got alive %b clear %b want 00000 1", alive, wave_clear); else n_pass++;
    n_checks++; if (score !== 16'd50 || score_s !== 6'd50) $display("FAIL wave_score got %0d/%0d want 50/50", score, score_s); else n_pass++;
    Start = 1'b1; step(1); Start = 1'b0; step(1);
    n_checks++; if (alive !== 5'b11111 || wave_clear !== 1'b0 || score !== 16'd50) $display("FAIL rearm got alive %b clear %b score %0d want 11111 0 50", alive, wave_clear, score); else n_pass++;
    drive_hit(5'b00001, 5, 5); frame_pulse(p);
    drive_hit(5'b00010, 5, 5); frame_pulse(p);
    n_checks++; if (score !== 16'd70) $display("FAIL score_after_rearm got %0d want 70", score); else n_pass++;
    n_checks++; if (score_s !== 6'd63) $display("FAIL score_saturate got %0d want 63", score_s); else n_pass++;
  endtask

  task automatic test_reset_pending();
    int p;
    drive_hit(5'b00100, 50, 50);
    Reset = 1'b1; step(1);
    Reset = 1'b0; step(1);
    frame_pulse(p);
    n_checks++; if (p !== 0 || alive !== 5'b00000 || score !== 16'd0 || score_s !== 6'd0) $display("FAIL reset_pending got pulses %0d alive %b score %0d/%0d want 0 00000 0/0", p, alive, score, score_s); else n_pass++;
    Start = 1'b1; step(1); Start = 1'b0; step(1);
    frame_pulse(p);
    n_checks++; if (p !== 0 || alive !== 5'b11111) $display("FAIL reset_pending_discard got pulses %0d alive %b want 0 11111", p, alive); else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] m_alive, v;
    int m_score, m_score_s, m_idx, p, exp_p;
    bit m_pend;
    restart();
    m_alive = 5'b11111; m_score = 0; m_score_s = 0; m_pend = 0; m_idx = 0;
    for (int f = 0; f < 30; f++) begin
      if (m_alive == 5'b00000) begin
        n_checks++; if (wave_clear !== 1'b1) $display("FAIL rand_wave_clear frame %0d got %b want 1", f, wave_clear); else n_pass++;
        Start = 1'b1; step(1); Start = 1'b0; step(1);
        m_alive = 5'b11111;
      end
      for (int c = 0; c < 16; c++) begin
        enemy_on_vec = 5'($urandom);
        missile_on   = ($urandom_range(0, 3) == 0);
        DrawX        = 10'($urandom_range(0, 799));
        DrawY        = 10'($urandom_range(0, 524));
        v = enemy_on_vec & m_alive;
        if (!m_pend && missile_on && DrawX < 640 && DrawY < 480 && v != 0) begin
          m_pend = 1;
          m_idx = 0;
          while (!v[m_idx]) m_idx++;
        end
        step(1);
      end
      enemy_on_vec = '0; missile_on = 1'b0; DrawX = '0; DrawY = '0;
      frame_pulse(p);
      exp_p = m_pend ? 1 : 0;
      if (m_pend) begin
        m_alive[m_idx] = 1'b0;
        m_score   = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        m_score_s = (m_score_s + 10 > 63) ? 63 : m_score_s + 10;
        m_pend = 0;
      end
      n_checks++; if (p !== exp_p || (exp_p == 1 && last_idx !== 3'(m_idx))) $display("FAIL rand_pulse frame %0d got %0d idx %0d want %0d idx %0d", f, p, last_idx, exp_p, m_idx); else n_pass++;
      n_checks++; if (alive !== m_alive || score !== 16'(m_score) || score_s !== 6'(m_score_s)) $display("FAIL rand_state frame %0d got %b %0d %0d want %b %0d %0d", f, alive, score, score_s, m_alive, m_score, m_score_s); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_priority_and_bounds();
    test_two_hits_one_frame();
    test_tick_same_cycle();
    test_wave_clear_and_saturation();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
